// File: rtl/img_pkg.sv
// Shared definitions for the window-filter front end: pixel width,
// default frame geometry and the feeder state encoding.
package img_pkg;

  localparam int PIX_W          = 8;
  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of storage: single-port synchronous RAM, read-first, so a
// write and a read at the same address return the old contents.
module line_buffer
  import img_pkg::*;
#(
  parameter int DEPTH = IMG_WIDTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] dout_o
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= din_i;
    end
    dout_o <= mem[addr_i];
  end

endmodule

// File: rtl/pixel_column_feeder.sv
// Raster-to-column feeder: buffers two rows and emits (y-2, y-1, y) triples
// for every pixel accepted from row 2 onward, with coordinates and end-of-frame.
module pixel_column_feeder
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int XW         = $clog2(IMG_WIDTH),
  parameter int YW         = $clog2(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sof,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_in_valid,
  output logic             pix_in_ready,
  output logic [PIX_W-1:0] col_top,
  output logic [PIX_W-1:0] col_mid,
  output logic [PIX_W-1:0] col_bot,
  output logic             col_valid,
  output logic [XW-1:0]    col_x,
  output logic [YW-1:0]    col_y,
  output logic             frame_done
);

  feeder_state_t    state_q, state_d;
  logic [XW-1:0]    xPos_q, xPos_d;
  logic [YW-1:0]    yPos_q, yPos_d;
  logic             ready_q;
  logic             s1Valid_q, doneS1_q;
  logic [PIX_W-1:0] s1Pix_q;
  logic [XW-1:0]    s1X_q;
  logic [YW-1:0]    s1Y_q;
  logic [PIX_W-1:0] colTop_q, colMid_q, colBot_q;
  logic             colValid_q, frameDone_q;
  logic [XW-1:0]    colX_q;
  logic [YW-1:0]    colY_q;

  logic             accept, lastCol, lastRow;
  logic             lbWe0, lbWe1, emit, readyNext, doneNext;
  logic [XW-1:0]    lbAddr;
  logic [PIX_W-1:0] lbDout0, lbDout1;

  assign accept  = pix_in_valid && ready_q;
  assign lastCol = (xPos_q == XW'(IMG_WIDTH - 1));
  assign lastRow = (yPos_q == YW'(IMG_HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xPos_q  <= '0;
      yPos_q  <= '0;
    end else begin
      state_q <= state_d;
      xPos_q  <= xPos_d;
      yPos_q  <= yPos_d;
    end
  end

  // A start-of-frame outside IDLE restarts at (0,0) and consumes any pixel presented with it.
  always_comb begin
    state_d = state_q;
    xPos_d  = xPos_q;
    yPos_d  = yPos_q;
    if (sof) begin
      state_d = FILL;
      yPos_d  = '0;
      xPos_d  = accept ? XW'(1) : '0;
    end else begin
      case (state_q)
        IDLE: ;
        FILL, STREAM: begin
          if (accept) begin
            if (lastCol) begin
              xPos_d = '0;
              if (state_q == STREAM && lastRow) begin
                yPos_d  = '0;
                state_d = DONE;
              end else begin
                yPos_d = yPos_q + 1'b1;
                if (state_q == FILL && yPos_q[0]) begin
                  state_d = STREAM;
                end
              end
            end else begin
              xPos_d = xPos_q + 1'b1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    lbAddr    = sof ? '0 : xPos_q;
    lbWe0     = accept && (sof || !yPos_q[0]);
    lbWe1     = accept && !sof && yPos_q[0];
    emit      = accept && !sof && (state_q == STREAM);
    readyNext = (state_d == FILL) || (state_d == STREAM);
    doneNext  = (state_q == DONE) && !sof;
  end

  line_buffer #(.DEPTH(IMG_WIDTH), .AW(XW)) u_lb0 (
    .clk    (clk),
    .we_i   (lbWe0),
    .addr_i (lbAddr),
    .din_i  (pix_in),
    .dout_o (lbDout0)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .AW(XW)) u_lb1 (
    .clk    (clk),
    .we_i   (lbWe1),
    .addr_i (lbAddr),
    .din_i  (pix_in),
    .dout_o (lbDout1)
  );

  // Stage 1 lines the accepted pixel up with the RAM read; stage 2 launches all outputs together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      s1Valid_q   <= 1'b0;
      s1Pix_q     <= '0;
      s1X_q       <= '0;
      s1Y_q       <= '0;
      doneS1_q    <= 1'b0;
      colTop_q    <= '0;
      colMid_q    <= '0;
      colBot_q    <= '0;
      colValid_q  <= 1'b0;
      colX_q      <= '0;
      colY_q      <= '0;
      frameDone_q <= 1'b0;
    end else begin
      ready_q     <= readyNext;
      s1Valid_q   <= emit;
      doneS1_q    <= doneNext;
      colValid_q  <= s1Valid_q;
      frameDone_q <= doneS1_q;
      if (emit) begin
        s1Pix_q <= pix_in;
        s1X_q   <= xPos_q;
        s1Y_q   <= yPos_q;
      end
      if (s1Valid_q) begin
        colTop_q <= s1Y_q[0] ? lbDout1 : lbDout0;
        colMid_q <= s1Y_q[0] ? lbDout0 : lbDout1;
        colBot_q <= s1Pix_q;
        colX_q   <= s1X_q;
        colY_q   <= s1Y_q;
      end
    end
  end

  assign pix_in_ready = ready_q;
  assign col_top      = colTop_q;
  assign col_mid      = colMid_q;
  assign col_bot      = colBot_q;
  assign col_valid    = colValid_q;
  assign col_x        = colX_q;
  assign col_y        = colY_q;
  assign frame_done   = frameDone_q;

endmodule
